hps_cmd_decoder: RTL and testbench

Frames and decodes the 16-bit command/payload word stream delivered by the HPS SPI interface into core-visible registers: buttons, joystick 0 and the 32-bit status word. It sits directly downstream of the HPS SPI interface, consuming its `gp_out` frame-enable and word bits plus the `io_strobe` word-complete pulse. It drives `gp_in`, the response word returned to the HPS on the next SPI exchange.

---
 rtl/hps_cmd_decoder.sv | 129 ++++++++++++
 tb/tb_hps_cmd_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_cmd_decoder.sv
// Command/payload decoder for the HPS SPI word stream: frames words, updates core registers.
// Optional STATUS_GET (0x29) readback of the status word is enabled by HPS_CMD_STATUS_READBACK_EN.
module hps_cmd_decoder #(
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] gp_out,
  input  logic        io_strobe,
  output logic [15:0] gp_in,
  output logic [15:0] cmd,
  output logic        cmd_strobe,
  output logic        frame_active,
  output logic [15:0] buttons,
  output logic [31:0] joystick_0,
  output logic [31:0] status,
  output logic        status_set
);

  localparam logic [7:0] CMD_BUTTONS    = 8'h01;
  localparam logic [7:0] CMD_JOY0       = 8'h02;
  localparam logic [7:0] CMD_STATUS_SET = 8'h1E;
  localparam logic [7:0] CMD_STATUS_GET = 8'h29;

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        io_en;
  logic [15:0] word;
  logic        accept;
  logic        cmd_accept;
  logic [7:0]  word_cnt;
  logic [15:0] joy_lo;
  logic [15:0] st_lo;
  logic [15:0] resp;
  logic        unused_bits;

  assign io_en       = gp_out[20];
  assign word        = gp_out[15:0];
  assign accept      = io_strobe & io_en;
  assign cmd_accept  = accept & (word_cnt == 8'd0);
  assign unused_bits = ^{gp_out[31:21], gp_out[19:16]};

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_accept) state_d = FRAME;
      FRAME:   if (!io_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_active = (state_q == FRAME);

  // On the command word the new command is the incoming word itself, not cmd.
  always_comb begin
    resp = 16'h0000;
`ifdef HPS_CMD_STATUS_READBACK_EN
    if (word_cnt == 8'd0) begin
      if (word[7:0] == CMD_STATUS_GET) resp = status[15:0];
    end else if (word_cnt == 8'd1 && cmd[7:0] == CMD_STATUS_GET) begin
      resp = status[31:16];
    end
`endif
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      gp_in      <= 16'h0000;
      cmd        <= 16'h0000;
      cmd_strobe <= 1'b0;
      buttons    <= 16'h0000;
      joystick_0 <= 32'h0000_0000;
      status     <= STATUS_RST;
      status_set <= 1'b0;
      joy_lo     <= 16'h0000;
      st_lo      <= 16'h0000;
      word_cnt   <= 8'd0;
    end else begin
      cmd_strobe <= 1'b0;
      status_set <= 1'b0;
      if (!io_en) begin
        word_cnt <= 8'd0;
        gp_in    <= 16'h0000;
      end else if (io_strobe) begin
        gp_in <= resp;
        if (word_cnt == 8'd0) begin
          cmd        <= word;
          cmd_strobe <= 1'b1;
          word_cnt   <= 8'd1;
        end else begin
          if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
          // Multi-word values go through a shadow so the commit is a single update.
          case (cmd[7:0])
            CMD_BUTTONS: begin
              if (word_cnt == 8'd1) buttons <= word;
            end
            CMD_JOY0: begin
              if (word_cnt == 8'd1) joy_lo <= word;
              else if (word_cnt == 8'd2) joystick_0 <= {word, joy_lo};
            end
            CMD_STATUS_SET: begin
              if (word_cnt == 8'd1) begin
                st_lo <= word;
              end else if (word_cnt == 8'd2) begin
                status     <= {word, st_lo};
                status_set <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hps_cmd_decoder.sv
// Scoreboard bench for hps_cmd_decoder: stimulus queues expectations, a negedge monitor checks them.
// Readback expectations follow HPS_CMD_STATUS_READBACK_EN when it is defined for the build.
module tb_hps_cmd_decoder;

  localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

  localparam int S_STATUS  = 0;
  localparam int S_CMD     = 1;
  localparam int S_BUTTONS = 2;
  localparam int S_JOY     = 3;
  localparam int S_GP_IN   = 4;
  localparam int S_FA      = 5;
  localparam int S_CS      = 6;
  localparam int S_SS      = 7;
  localparam int S_PENDING = 8;

`ifdef HPS_CMD_STATUS_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } chk_t;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [31:0] gp_out;
  logic        io_strobe;
  logic [15:0] gp_in;
  logic [15:0] cmd;
  logic        cmd_strobe;
  logic        frame_active;
  logic [15:0] buttons;
  logic [31:0] joystick_0;
  logic [31:0] status;
  logic        status_set;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cmd_q[$];
  logic [31:0] exp_status_q[$];
  chk_t        chk_q[$];
  chk_t        cur;
  logic [15:0] exp_c;
  logic [31:0] exp_s;
  logic [31:0] act;

  hps_cmd_decoder #(.STATUS_RST(RST_VAL)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .gp_out      (gp_out),
    .io_strobe   (io_strobe),
    .gp_in       (gp_in),
    .cmd         (cmd),
    .cmd_strobe  (cmd_strobe),
    .frame_active(frame_active),
    .buttons     (buttons),
    .joystick_0  (joystick_0),
    .status      (status),
    .status_set  (status_set)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic string name_of(int sel);
    case (sel)
      S_STATUS:  return "status";
      S_CMD:     return "cmd";
      S_BUTTONS: return "buttons";
      S_JOY:     return "joystick_0";
      S_GP_IN:   return "gp_in";
      S_FA:      return "frame_active";
      S_CS:      return "cmd_strobe";
      S_SS:      return "status_set";
      S_PENDING: return "pending_pulses";
      default:   return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual_of(int sel);
    case (sel)
      S_STATUS:  return status;
      S_CMD:     return {16'h0, cmd};
      S_BUTTONS: return {16'h0, buttons};
      S_JOY:     return joystick_0;
      S_GP_IN:   return {16'h0, gp_in};
      S_FA:      return {31'h0, frame_active};
      S_CS:      return {31'h0, cmd_strobe};
      S_SS:      return {31'h0, status_set};
      S_PENDING: return 32'(exp_cmd_q.size() + exp_status_q.size());
      default:   return 32'hDEAD_DEAD;
    endcase
  endfunction

  // Monitor: the only process that compares and counts.
  always @(negedge sys_clk) begin
    if (cmd_strobe) begin
      tests++;
      if (exp_cmd_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL cmd_strobe_unexpected: got pulse with cmd=%h, required no pulse", cmd);
      end else begin
        exp_c = exp_cmd_q.pop_front();
        if (cmd !== exp_c) begin
          fails++;
          $display("[TB] FAIL cmd_on_strobe: got %h, required %h", cmd, exp_c);
        end
      end
    end
    if (status_set) begin
      tests++;
      if (exp_status_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL status_set_unexpected: got pulse with status=%h, required no pulse", status);
      end else begin
        exp_s = exp_status_q.pop_front();
        if (status !== exp_s) begin
          fails++;
          $display("[TB] FAIL status_on_set: got %h, required %h", status, exp_s);
        end
      end
    end
    while (chk_q.size() > 0) begin
      cur = chk_q.pop_front();
      act = actual_of(cur.sel);
      tests++;
      if (act !== cur.exp) begin
        fails++;
        $display("[TB] FAIL %s: got %h, required %h", name_of(cur.sel), act, cur.exp);
      end
    end
  end

  task automatic check_output(input int sel, input logic [31:0] exp);
    chk_t c;
    c.sel = sel;
    c.exp = exp;
    chk_q.push_back(c);
  endtask

  // Drives one strobed word for one cycle; returns 1 time unit after the capturing edge.
  task automatic apply_stimulus(input logic en, input logic [15:0] w);
    gp_out    = {11'h0, en, 4'h0, w};
    io_strobe = 1'b1;
    @(posedge sys_clk);
    #1;
    io_strobe = 1'b0;
  endtask

  task automatic idle(input int n, input logic en);
    gp_out[20] = en;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    io_strobe = 1'b0;
    gp_out    = 32'h0;
    repeat (3) @(posedge sys_clk);
    #1;
    reset = 1'b0;
    check_output(S_STATUS, RST_VAL);
    check_output(S_CMD, 32'h0);
    check_output(S_BUTTONS, 32'h0);
    check_output(S_JOY, 32'h0);
    check_output(S_GP_IN, 32'h0);
    check_output(S_FA, 32'h0);
    check_output(S_CS, 32'h0);
    check_output(S_SS, 32'h0);

    // STATUS_SET frame
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h001E);
    apply_stimulus(1'b1, 16'h001E);
    check_output(S_FA, 32'h1);
    check_output(S_CMD, 32'h001E);
    apply_stimulus(1'b1, 16'h1234);
    check_output(S_STATUS, RST_VAL);
    exp_status_q.push_back(32'hBEEF_1234);
    apply_stimulus(1'b1, 16'hBEEF);
    check_output(S_STATUS, 32'hBEEF_1234);
    idle(1, 1'b0);
    check_output(S_FA, 32'h0);

    // Truncated JOY0 frame, then a complete one
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h0002);
    apply_stimulus(1'b1, 16'h0002);
    apply_stimulus(1'b1, 16'h5555);
    idle(1, 1'b0);
    check_output(S_JOY, 32'h0);
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h0002);
    apply_stimulus(1'b1, 16'h0002);
    apply_stimulus(1'b1, 16'h0001);
    check_output(S_JOY, 32'h0);
    apply_stimulus(1'b1, 16'h0002);
    check_output(S_JOY, 32'h0002_0001);
    idle(1, 1'b0);

    // Strobe with io_en low is ignored; BUTTONS frame
    apply_stimulus(1'b0, 16'h0001);
    check_output(S_CMD, 32'h0002);
    check_output(S_BUTTONS, 32'h0);
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h0001);
    apply_stimulus(1'b1, 16'h0001);
    apply_stimulus(1'b1, 16'h00F0);
    check_output(S_BUTTONS, 32'h00F0);
    apply_stimulus(1'b1, 16'h1111);
    check_output(S_BUTTONS, 32'h00F0);
    check_output(S_JOY, 32'h0002_0001);
    check_output(S_STATUS, 32'hBEEF_1234);
    idle(1, 1'b0);

    // STATUS_GET readback
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h0029);
    apply_stimulus(1'b1, 16'h0029);
    check_output(S_GP_IN, READBACK ? 32'h1234 : 32'h0);
    apply_stimulus(1'b1, 16'h0000);
    check_output(S_GP_IN, READBACK ? 32'hBEEF : 32'h0);
    idle(1, 1'b1);
    check_output(S_GP_IN, READBACK ? 32'hBEEF : 32'h0);
    apply_stimulus(1'b1, 16'h0000);
    check_output(S_GP_IN, 32'h0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h0029);
    apply_stimulus(1'b1, 16'h0029);
    check_output(S_GP_IN, READBACK ? 32'h1234 : 32'h0);
    idle(1, 1'b0);
    check_output(S_GP_IN, 32'h0);

    // Strobe coinciding with io_en fall ends the frame without effect
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h0001);
    apply_stimulus(1'b1, 16'h0001);
    apply_stimulus(1'b0, 16'h7777);
    check_output(S_BUTTONS, 32'h00F0);
    check_output(S_FA, 32'h0);

    // Reset between STATUS_SET payload words
    idle(1, 1'b1);
    exp_cmd_q.push_back(16'h001E);
    apply_stimulus(1'b1, 16'h001E);
    apply_stimulus(1'b1, 16'hCAFE);
    reset = 1'b1;
    #1;
    check_output(S_STATUS, RST_VAL);
    check_output(S_FA, 32'h0);
    check_output(S_CMD, 32'h0);
    check_output(S_BUTTONS, 32'h0);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    exp_cmd_q.push_back(16'h0001);
    apply_stimulus(1'b1, 16'h0001);
    check_output(S_CMD, 32'h0001);
    check_output(S_FA, 32'h1);
    apply_stimulus(1'b1, 16'h00AA);
    check_output(S_BUTTONS, 32'h00AA);
    check_output(S_STATUS, RST_VAL);
    idle(4, 1'b0);
    check_output(S_PENDING, 32'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
